// File: rtl/fp_add_sub_pipe.sv
`default_nettype none
// ============================================================================
// fp_add_sub_pipe : 3-stage flush-to-zero IEEE-754 adder/subtractor, valid/ready
// Option: define FP_ADD_SUB_RNE_EN for round-to-nearest-even, else truncation.
// Rev 1.0
// ============================================================================
module fp_add_sub_pipe #(
    parameter int EXP_W = 8,
    parameter int MTS_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MTS_W:0] a,
    input  logic [EXP_W+MTS_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MTS_W:0] result,
    output logic                 is_zero,
    output logic                 overflow,
    output logic                 invalid
);
    localparam int W     = 1 + EXP_W + MTS_W;
    localparam int FW    = MTS_W + 4;
    localparam int LZC_W = $clog2(FW + 2);
    localparam int EW    = EXP_W + 2;
    localparam logic [EXP_W-1:0]     EMAX   = {EXP_W{1'b1}};
    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;
`ifdef FP_ADD_SUB_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: order, align, classify ----------------
    logic             sb, sx, sy, a_ge_b;
    logic             a_nan, a_inf, b_nan, b_inf;
    logic [W-2:0]     mag_a, mag_b;
    logic [EXP_W-1:0] ex, ey, diff;
    logic [MTS_W-1:0] mx, my;
    logic [FW-1:0]    fy, fx1_d, fy1_d;
    logic [1:0]       sp1_d;
    logic             esub1_d, infs1_d;

    always_comb begin
        sb     = b[W-1] ^ sub;
        mag_a  = (a[W-2:MTS_W] == '0) ? '0 : a[W-2:0];
        mag_b  = (b[W-2:MTS_W] == '0) ? '0 : b[W-2:0];
        a_ge_b = mag_a >= mag_b;
        {sx, ex, mx} = a_ge_b ? a : {sb, b[W-2:0]};
        {sy, ey, my} = a_ge_b ? {sb, b[W-2:0]} : a;
        fx1_d = (ex == '0) ? '0 : {1'b1, mx, 3'b000};
        fy    = (ey == '0) ? '0 : {1'b1, my, 3'b000};
        diff  = ex - ey;
        if (32'(diff) >= 32'(FW - 1)) begin
            fy1_d = {{(FW-1){1'b0}}, |fy};
        end else begin
            fy1_d    = fy >> diff;
            fy1_d[0] = fy1_d[0] | (|(fy & ~({FW{1'b1}} << diff)));
        end
        esub1_d = sx ^ sy;
        a_nan   = (a[W-2:MTS_W] == EMAX) && (a[MTS_W-1:0] != '0);
        a_inf   = (a[W-2:MTS_W] == EMAX) && (a[MTS_W-1:0] == '0);
        b_nan   = (b[W-2:MTS_W] == EMAX) && (b[MTS_W-1:0] != '0);
        b_inf   = (b[W-2:MTS_W] == EMAX) && (b[MTS_W-1:0] == '0);
        infs1_d = a_inf ? a[W-1] : sb;
        if (a_nan || b_nan || (a_inf && b_inf && (a[W-1] != sb)))
            sp1_d = SP_NAN;
        else if (a_inf || b_inf)
            sp1_d = SP_INF;
        else
            sp1_d = SP_NONE;
    end

    logic             v1_q, sx1_q, esub1_q, infs1_q;
    logic [EXP_W-1:0] e1_q;
    logic [FW-1:0]    fx1_q, fy1_q;
    logic [1:0]       sp1_q;

    // ---------------- S2: add/subtract, leading-zero count ----------------
    function automatic logic [LZC_W-1:0] lzc(input logic [FW:0] v);
        logic [LZC_W-1:0] n;
        n = LZC_W'(FW + 1);
        for (int i = 0; i <= FW; i++)
            if (v[i]) n = LZC_W'(FW - i);
        return n;
    endfunction

    logic [FW:0]      sum2_d;
    logic [LZC_W-1:0] lzc2_d;

    always_comb begin
        sum2_d = esub1_q ? ({1'b0, fx1_q} - {1'b0, fy1_q})
                         : ({1'b0, fx1_q} + {1'b0, fy1_q});
        lzc2_d = lzc(sum2_d);
    end

    logic             v2_q, s2_q, esub2_q, infs2_q;
    logic [EXP_W-1:0] e2_q;
    logic [FW:0]      sum2_q;
    logic [LZC_W-1:0] lzc2_q;
    logic [1:0]       sp2_q;

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZC_W-1:0]       sh;
    logic [FW-1:0]          norm;
    logic signed [EW-1:0]   e_n, e_r;
    logic                   inc;
    logic [MTS_W+1:0]       rnd;
    logic [MTS_W-1:0]       mts;
    logic [W-1:0]           res3_d;
    logic                   zero3_d, ovf3_d, inv3_d;

    always_comb begin
        sh = lzc2_q - LZC_W'(1);
        if (sum2_q[FW]) begin
            norm    = sum2_q[FW:1];
            norm[0] = sum2_q[1] | sum2_q[0];
            e_n     = EW'(e2_q) + EW'(1);
        end else begin
            norm = sum2_q[FW-1:0] << sh;
            e_n  = EW'(e2_q) - EW'(sh);
        end
        // norm[2:0] are guard/round/sticky; truncation never increments.
        inc = RNE & norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd = {1'b0, norm[FW-1:3]} + (MTS_W+2)'(inc);
        if (rnd[MTS_W+1]) begin
            mts = rnd[MTS_W:1];
            e_r = e_n + EW'(1);
        end else begin
            mts = rnd[MTS_W-1:0];
            e_r = e_n;
        end
        res3_d = '0;
        ovf3_d = 1'b0;
        inv3_d = 1'b0;
        if (sp2_q == SP_NAN) begin
            res3_d = {1'b0, EMAX, 1'b1, {(MTS_W-1){1'b0}}};
            inv3_d = 1'b1;
        end else if (sp2_q == SP_INF) begin
            res3_d = {infs2_q, EMAX, {MTS_W{1'b0}}};
        end else if (sum2_q == '0) begin
            res3_d = {s2_q & !esub2_q, {(W-1){1'b0}}};
        end else if (e_r >= EMAX_S) begin
            res3_d = {s2_q, EMAX, {MTS_W{1'b0}}};
            ovf3_d = 1'b1;
        end else if (e_r[EW-1] || (e_r == '0)) begin
            res3_d = {s2_q, {(W-1){1'b0}}};
        end else begin
            res3_d = {s2_q, e_r[EXP_W-1:0], mts};
        end
        zero3_d = (res3_d[W-2:0] == '0);
    end

    logic         v3_q, zero3_q, ovf3_q, inv3_q;
    logic [W-1:0] res3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;  sx1_q   <= 1'b0;  esub1_q <= 1'b0;  infs1_q <= 1'b0;
            e1_q    <= '0;    fx1_q   <= '0;    fy1_q   <= '0;    sp1_q   <= SP_NONE;
            v2_q    <= 1'b0;  s2_q    <= 1'b0;  esub2_q <= 1'b0;  infs2_q <= 1'b0;
            e2_q    <= '0;    sum2_q  <= '0;    lzc2_q  <= '0;    sp2_q   <= SP_NONE;
            v3_q    <= 1'b0;  res3_q  <= '0;    zero3_q <= 1'b0;
            ovf3_q  <= 1'b0;  inv3_q  <= 1'b0;
        end else if (adv) begin
            v1_q    <= in_valid;  sx1_q   <= sx;       esub1_q <= esub1_d;  infs1_q <= infs1_d;
            e1_q    <= ex;        fx1_q   <= fx1_d;    fy1_q   <= fy1_d;    sp1_q   <= sp1_d;
            v2_q    <= v1_q;      s2_q    <= sx1_q;    esub2_q <= esub1_q;  infs2_q <= infs1_q;
            e2_q    <= e1_q;      sum2_q  <= sum2_d;   lzc2_q  <= lzc2_d;   sp2_q   <= sp1_q;
            v3_q    <= v2_q;      res3_q  <= res3_d;   zero3_q <= zero3_d;
            ovf3_q  <= ovf3_d;    inv3_q  <= inv3_d;
        end
    end

    assign out_valid = v3_q;
    assign result    = res3_q;
    assign is_zero   = zero3_q;
    assign overflow  = ovf3_q;
    assign invalid   = inv3_q;

endmodule
`default_nettype wire
